fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction queue between the fetch interface (PC + CCM controller) and decode.
//  Issues one-word read requests, pairs each 1-cycle-latency response with its PC, and
//  buffers pairs in a DEPTH-entry circular FIFO. Presents them to decode with a
//  valid/ready handshake. Flush on redirect drops queued words and the in-flight word.
// PARAMETERS
//  ADDR_WIDTH  11  word-address width of PC / CCM
//  DATA_WIDTH  32  instruction width
//  DEPTH       4   queue entries, power of two, >=2
//  NOP_INSTR   32'h00000013  value on id_instr while id_valid=0
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  flush        in   1           redirect: discard queue and in-flight word
//  fetch_pc     in   ADDR_WIDTH  PC of the word being requested this cycle
//  fetch_req    out  1           read request (drives cntlr_rd); also PC advance enable
//  rsp_valid    in   1           cntlr_rd_valid
//  rsp_data     in   DATA_WIDTH  cntlr_rd_data
//  id_valid     out  1           head entry valid
//  id_instr     out  DATA_WIDTH  head instruction, NOP_INSTR when empty
//  id_pc        out  ADDR_WIDTH  head PC, 0 when empty
//  id_ready     in   1           decode accepts head this cycle
//  rsp_err      out  1           sticky: response with no outstanding request
// BEHAVIOUR
//  Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, count=0, inflight=0, drop=0, rsp_err=0;
//   outputs: fetch_req=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0.
//  State: count 0..DEPTH, inflight 0/1, inflight_pc reg, drop 0/1.
//  fetch_req = !rst && !flush && (count + inflight) < DEPTH  (combinational credit).
//  Issue: fetch_req=1 -> next cycle inflight=1, inflight_pc<=fetch_pc.
//   The same cycle's rsp_valid retires the previous request, so back-to-back issue
//   sustains 1 word/cycle.
//  Response: the CCM answers exactly 1 cycle after the request.
//   rsp_valid with inflight=1, drop=0 -> push {inflight_pc, rsp_data} at wr_ptr.
//   rsp_valid with drop=1 -> discard, clear drop.
//   rsp_valid with inflight=0 -> ignore data, set rsp_err.
//  Pop: id_valid && id_ready -> rd_ptr++. id_valid = (count!=0).
//   id_instr and id_pc read combinationally from mem[rd_ptr].
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//   Push into a full queue cannot occur (credit rule). Pop from empty is ignored.
//  Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
//  Flush (highest priority below rst): count<=0, rd_ptr<=wr_ptr<=0, fetch_req=0.
//   A response arriving in the flush cycle is discarded.
//   If inflight=1 and no rsp this cycle, drop<=1 so the late response is discarded.
//   A pop in the flush cycle is not performed.
//  rst while requests are in flight: state cleared. A response in the following cycle
//   arrives with inflight=0 and is ignored. It also sets rsp_err, except in the first
//   cycle after reset, which is masked.
//  Latency: fetch_req at cycle N -> word pushed at end of N+1 -> id_valid at N+2.
// TESTING
//  1 Reset then stream, id_ready=1, pc 0,1,2..: fetch_req high every cycle;
//    first id_valid 2 cycles after first req; id_pc 0,1,2 in order with matching data.
//  2 id_ready=0 from start: exactly DEPTH=4 requests issued, then fetch_req=0 and
//    count=4. Raise id_ready -> 4 pops in order, requests resume.
//  3 Wrap: 10 words through DEPTH=4 with id_ready toggling 1/0 -> no loss or duplicate;
//    order preserved across ptr 3->0.
//  4 Flush with 2 queued words and 1 in flight -> id_valid=0 next cycle; late rsp
//    (0xDEADBEEF) discarded; next word after redirect pc=0x40 appears with id_pc=0x40.
//  5 Spurious rsp_valid with no request -> queue unchanged, rsp_err=1 until rst.
//  6 Empty queue: id_instr=32'h00000013, id_pc=0. Simultaneous push/pop at count=1
//    -> count stays 1.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch/decode interface of the instruction queue: CCM request/response on one side,
// decode valid/ready handshake on the other.
interface fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  flush;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fetch_req;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  id_valid;
  logic [DATA_WIDTH-1:0] id_instr;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic                  id_ready;
  logic                  rsp_err;

  // Environment side: PC/CCM controller and decode stage.
  modport master (
    output flush, fetch_pc, rsp_valid, rsp_data, id_ready,
    input  fetch_req, id_valid, id_instr, id_pc, rsp_err
  );

  // Queue side.
  modport slave (
    input  flush, fetch_pc, rsp_valid, rsp_data, id_ready,
    output fetch_req, id_valid, id_instr, id_pc, rsp_err
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: issues one-word CCM reads under a credit
// rule, pairs each 1-cycle response with its PC and buffers pairs in a circular FIFO.
module fetch_queue #(
  parameter int unsigned          ADDR_WIDTH = 11,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h00000013)
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  drop_q, drop_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  mask_q, mask_d;

  logic credit_ok_c;
  logic fetch_req_c;
  logic head_valid_c;
  logic push_c;
  logic pop_c;

  // Queued words plus the in-flight word may never exceed the queue depth.
  assign credit_ok_c  = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
  assign fetch_req_c  = !rst && !bus.flush && credit_ok_c;
  assign head_valid_c = (count_q != '0);
  assign push_c       = bus.rsp_valid && inflight_q && !drop_q && !bus.flush;
  assign pop_c        = head_valid_c && bus.id_ready && !bus.flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    mask_d        = 1'b0;
    // A response nobody asked for is sticky, except right after reset.
    rsp_err_d     = rsp_err_q | (bus.rsp_valid && !inflight_q && !drop_q && !mask_q);

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      drop_d     = (inflight_q || drop_q) && !bus.rsp_valid;
    end else begin
      inflight_d = fetch_req_c;
      if (fetch_req_c) begin
        inflight_pc_d = bus.fetch_pc;
      end
      if (bus.rsp_valid && drop_q) begin
        drop_d = 1'b0;
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
      rsp_err_q     <= 1'b0;
      mask_q        <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      rsp_err_q     <= rsp_err_d;
      mask_q        <= mask_d;
    end
  end

  // Payload storage needs no reset; id_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: bus.rsp_data};
    end
  end

  assign bus.fetch_req = fetch_req_c;
  assign bus.id_valid  = head_valid_c;
  assign bus.id_instr  = head_valid_c ? mem_q[rd_ptr_q].instr : NOP_INSTR;
  assign bus.id_pc     = head_valid_c ? mem_q[rd_ptr_q].pc : '0;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a 1-cycle CCM model answers requests, each task
// drives one scenario and checks hand-derived expectations at the falling edge.
module tb_fetch_queue;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   req_cnt;
  logic ccm_en;
  logic force_rsp;
  logic [DW-1:0] force_data;

  fetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) q_if ();

  fetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .NOP_INSTR(NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (q_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] p);
    return 32'hC0DE0000 + 32'(p);
  endfunction

  // One clock: sample request, CCM answers during the next cycle, return at negedge.
  task automatic step();
    logic req;
    logic [AW-1:0] p;
    #1;
    req = q_if.fetch_req;
    p   = q_if.fetch_pc;
    if (req) req_cnt++;
    @(posedge clk);
    #1;
    q_if.rsp_valid = (ccm_en && req) || force_rsp;
    q_if.rsp_data  = force_rsp ? force_data : instr_of(p);
    if (req) q_if.fetch_pc = AW'(p + 1'b1);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    q_if.flush = 1'b0; q_if.id_ready = 1'b0; q_if.rsp_valid = 1'b0;
    q_if.rsp_data = '0; q_if.fetch_pc = '0;
    ccm_en = 1'b0; force_rsp = 1'b0; force_data = '0;
    step(); step();
    rst = 1'b0;
    req_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    step();
    total++; if (q_if.fetch_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", q_if.fetch_req); end
    total++; if (q_if.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", q_if.id_valid); end
    total++; if (q_if.id_instr !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", q_if.id_instr, NOP); end
    total++; if (q_if.id_pc !== 11'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", q_if.id_pc); end
    total++; if (q_if.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", q_if.rsp_err); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    apply_reset();
    q_if.fetch_pc = '0; q_if.id_ready = 1'b1; ccm_en = 1'b1;
    #1;
    total++; if (q_if.fetch_req !== 1'b1) begin bad++; $display("FAIL s_req0: got %b want 1", q_if.fetch_req); end
    step();
    total++; if (q_if.id_valid !== 1'b0) begin bad++; $display("FAIL s_lat1: got %b want 0", q_if.id_valid); end
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] e;
      e = AW'(k);
      step();
      total++;
      if (q_if.id_valid !== 1'b1 || q_if.id_pc !== e || q_if.id_instr !== instr_of(e) || q_if.fetch_req !== 1'b1) begin
        bad++;
        $display("FAIL s_word%0d: got v=%b pc=%h i=%h req=%b want v=1 pc=%h i=%h req=1",
                 k, q_if.id_valid, q_if.id_pc, q_if.id_instr, q_if.fetch_req, e, instr_of(e));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    q_if.fetch_pc = 11'h010; q_if.id_ready = 1'b0; ccm_en = 1'b1;
    repeat (8) step();
    total++; if (req_cnt != 4) begin bad++; $display("FAIL bp_reqs: got %0d want 4", req_cnt); end
    total++; if (q_if.fetch_req !== 1'b0) begin bad++; $display("FAIL bp_full_req: got %b want 0", q_if.fetch_req); end
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h010) begin bad++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=010", q_if.id_valid, q_if.id_pc); end
    q_if.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] e;
      e = AW'(11'h010 + i);
      total++;
      if (q_if.id_valid !== 1'b1 || q_if.id_pc !== e || q_if.id_instr !== instr_of(e)) begin
        bad++;
        $display("FAIL bp_pop%0d: got v=%b pc=%h i=%h want pc=%h i=%h", i, q_if.id_valid, q_if.id_pc, q_if.id_instr, e, instr_of(e));
      end
      step();
    end
    total++; if (req_cnt != 8) begin bad++; $display("FAIL bp_resume_cnt: got %0d want 8", req_cnt); end
    #1;
    total++; if (q_if.fetch_req !== 1'b1) begin bad++; $display("FAIL bp_resume_req: got %b want 1", q_if.fetch_req); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] e;
    int popped;
    apply_reset();
    q_if.fetch_pc = 11'h020; ccm_en = 1'b1;
    e = 11'h020;
    popped = 0;
    for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
      q_if.id_ready = (cyc % 2 == 0);
      #1;
      if (q_if.id_valid && q_if.id_ready) begin
        total++;
        if (q_if.id_pc !== e || q_if.id_instr !== instr_of(e)) begin
          bad++;
          $display("FAIL wrap_word%0d: got pc=%h i=%h want pc=%h i=%h", popped, q_if.id_pc, q_if.id_instr, e, instr_of(e));
        end
        e = AW'(e + 1'b1);
        popped++;
      end
      step();
    end
    total++; if (popped != 10) begin bad++; $display("FAIL wrap_count: got %0d want 10", popped); end
  endtask

  task automatic test_flush();
    apply_reset();
    q_if.fetch_pc = 11'h030; q_if.id_ready = 1'b0; ccm_en = 1'b1;
    step(); step();
    ccm_en = 1'b0;
    step();
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h030) begin bad++; $display("FAIL fl_pre: got v=%b pc=%h want v=1 pc=030", q_if.id_valid, q_if.id_pc); end
    q_if.flush = 1'b1; force_rsp = 1'b1; force_data = 32'hDEADBEEF;
    #1;
    total++; if (q_if.fetch_req !== 1'b0) begin bad++; $display("FAIL fl_req: got %b want 0", q_if.fetch_req); end
    step();
    q_if.flush = 1'b0; force_rsp = 1'b0; q_if.fetch_pc = 11'h040; ccm_en = 1'b1;
    total++; if (q_if.id_valid !== 1'b0 || q_if.id_instr !== NOP) begin bad++; $display("FAIL fl_empty: got v=%b i=%h want v=0 i=%h", q_if.id_valid, q_if.id_instr, NOP); end
    #1;
    total++; if (q_if.fetch_req !== 1'b1) begin bad++; $display("FAIL fl_redirect_req: got %b want 1", q_if.fetch_req); end
    step();
    total++; if (q_if.id_valid !== 1'b0 || q_if.rsp_err !== 1'b0) begin bad++; $display("FAIL fl_late_drop: got v=%b err=%b want v=0 err=0", q_if.id_valid, q_if.rsp_err); end
    step();
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h040 || q_if.id_instr !== instr_of(11'h040)) begin bad++; $display("FAIL fl_new_word: got v=%b pc=%h i=%h want pc=040", q_if.id_valid, q_if.id_pc, q_if.id_instr); end
    // Flush while the response is on the bus: discarded outright, nothing left to drop.
    q_if.flush = 1'b1;
    step();
    q_if.flush = 1'b0; q_if.fetch_pc = 11'h050;
    total++; if (q_if.id_valid !== 1'b0) begin bad++; $display("FAIL fl2_empty: got %b want 0", q_if.id_valid); end
    step(); step();
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h050 || q_if.rsp_err !== 1'b0) begin bad++; $display("FAIL fl2_word: got v=%b pc=%h err=%b want v=1 pc=050 err=0", q_if.id_valid, q_if.id_pc, q_if.rsp_err); end
  endtask

  task automatic test_spurious();
    apply_reset();
    q_if.fetch_pc = 11'h060; q_if.id_ready = 1'b0; ccm_en = 1'b1;
    repeat (8) step();
    total++; if (q_if.fetch_req !== 1'b0 || q_if.rsp_err !== 1'b0) begin bad++; $display("FAIL sp_pre: got req=%b err=%b want 0 0", q_if.fetch_req, q_if.rsp_err); end
    force_rsp = 1'b1; force_data = 32'hBAD0BAD0;
    step();
    force_rsp = 1'b0;
    step();
    total++; if (q_if.rsp_err !== 1'b1) begin bad++; $display("FAIL sp_err: got %b want 1", q_if.rsp_err); end
    q_if.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] e;
      e = AW'(11'h060 + i);
      total++;
      if (q_if.id_valid !== 1'b1 || q_if.id_pc !== e || q_if.id_instr !== instr_of(e)) begin
        bad++;
        $display("FAIL sp_pop%0d: got v=%b pc=%h i=%h want pc=%h i=%h", i, q_if.id_valid, q_if.id_pc, q_if.id_instr, e, instr_of(e));
      end
      step();
    end
    total++; if (q_if.rsp_err !== 1'b1) begin bad++; $display("FAIL sp_sticky: got %b want 1", q_if.rsp_err); end
    rst = 1'b1; force_rsp = 1'b1;
    step();
    rst = 1'b0; force_rsp = 1'b0; q_if.fetch_pc = 11'h080;
    total++; if (q_if.rsp_err !== 1'b0) begin bad++; $display("FAIL sp_rst_clr: got %b want 0", q_if.rsp_err); end
    step();
    total++; if (q_if.rsp_err !== 1'b0) begin bad++; $display("FAIL sp_mask: got %b want 0", q_if.rsp_err); end
    step();
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h080) begin bad++; $display("FAIL sp_after_rst: got v=%b pc=%h want v=1 pc=080", q_if.id_valid, q_if.id_pc); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    q_if.fetch_pc = 11'h070; q_if.id_ready = 1'b0; ccm_en = 1'b1;
    step(); step();
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h070) begin bad++; $display("FAIL pp_one: got v=%b pc=%h want v=1 pc=070", q_if.id_valid, q_if.id_pc); end
    q_if.id_ready = 1'b1; ccm_en = 1'b0;
    step();
    total++; if (q_if.id_valid !== 1'b1 || q_if.id_pc !== 11'h071 || q_if.id_instr !== instr_of(11'h071)) begin bad++; $display("FAIL pp_swap: got v=%b pc=%h i=%h want pc=071", q_if.id_valid, q_if.id_pc, q_if.id_instr); end
    step();
    total++; if (q_if.id_valid !== 1'b0 || q_if.id_instr !== NOP || q_if.id_pc !== 11'h0) begin bad++; $display("FAIL pp_drained: got v=%b i=%h pc=%h want v=0 i=%h pc=0", q_if.id_valid, q_if.id_instr, q_if.id_pc, NOP); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_flush();
    test_spurious();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
